hamming_stream_encoder: RTL
===========================

HAMMING_STREAM_ENCODER -- requirements
Module: hamming_stream_encoder

Interface
REQ-001 Parameter DATA_W, default 4: data word width, legal range 1..57.
REQ-002 Parameter CNT_W, default 16: width of the delivered-word counter.
REQ-003 Derived P SHALL be the smallest integer with 2^P >= DATA_W+P+1; CODE_W = DATA_W+P (+1 with HAMMING_SECDED_EN).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream data valid.
REQ-007 s_ready  output  1  block can accept s_data.
REQ-008 s_data  input  DATA_W  data word to encode.
REQ-009 m_valid  output  1  m_code holds a valid codeword.
REQ-010 m_ready  input  1  downstream accepts m_code.
REQ-011 m_code  output  CODE_W  registered codeword.
REQ-012 inj_valid  input  1  one-cycle request to corrupt the next accepted word.
REQ-013 inj_pos  input  ceil(log2(CODE_W))  bit index to flip.
REQ-014 inj_pending  output  1  an injection request is armed.
REQ-015 word_cnt  output  CNT_W  count of codewords delivered (m_valid & m_ready).

Function
REQ-016 Layout SHALL be systematic: m_code[DATA_W-1:0] = data, m_code[DATA_W+i] = parity bit i for i in 0..P-1.
REQ-017 Data bit k SHALL map to the k-th Hamming position in ascending order of 1,2,3,... excluding powers of two (3,5,6,7,9,...).
REQ-018 Parity bit i SHALL be the XOR of all data bits whose mapped position has bit i set.
REQ-019 With DATA_W=4, parity SHALL be p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3.
REQ-020 Handshake: transfer on s_valid&s_ready; s_ready = !m_valid | m_ready (combinational, no other dependence).
REQ-021 Latency SHALL be one cycle from input transfer to m_valid; sustained throughput one word per cycle.
REQ-022 m_valid&!m_ready SHALL hold m_code and m_valid stable until transfer.
REQ-023 m_valid SHALL clear after an output transfer with no simultaneous input transfer.
REQ-024 inj_valid SHALL latch inj_pos and set inj_pending next cycle; a new request while pending overwrites the position.
REQ-025 On input transfer with inj_pending=1 (value at cycle start), m_code[inj_pos] SHALL be inverted after all parity is computed, and inj_pending cleared.
REQ-026 inj_valid coinciding with an input transfer SHALL arm for the following word, not the current one; it leaves inj_pending=1.
REQ-027 inj_pos >= CODE_W SHALL flip no bit but SHALL still be consumed.
REQ-028 word_cnt SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-029 rst_n low SHALL immediately force m_valid=0, m_code=0, inj_pending=0, latched inj_pos=0, word_cnt=0, independent of clk.
REQ-030 An in-flight codeword at reset SHALL be discarded; s_ready SHALL be 1 during and after reset.
REQ-031 Reset deassertion SHALL be the only condition needed to resume; first accepted word after reset has latency one.

Configuration
REQ-032 Macro HAMMING_SECDED_EN defined: m_code[CODE_W-1] SHALL be XOR of all data and parity bits (extended SECDED), computed before injection; injection may target this bit.
REQ-033 Macro HAMMING_SECDED_EN undefined: no overall parity bit; CODE_W = DATA_W+P.

Verification
REQ-034 DATA_W=4, s_data=4'b1011, m_ready=1 -> next cycle m_valid=1, m_code=7'h1B (8'h1B with SECDED); word_cnt=1 after transfer.
REQ-035 DATA_W=4, s_data=4'b0001 -> m_code=7'h31 (8'hB1 with SECDED).
REQ-036 m_ready=0 for 3 cycles holding word 4'b1011, s_valid=1 with 4'b0001 -> s_ready=0, m_code stays 7'h1B; on m_ready=1, 7'h31 follows next cycle, no loss or duplication.
REQ-037 inj_valid with inj_pos=2, then s_data=4'b1011 -> m_code=7'h1F, inj_pending clears; following 4'b1011 -> 7'h1B.
REQ-038 DATA_W=11 -> CODE_W=15 (16 with SECDED); walking-one data across all 11 bits matches REQ-018 reference model.
REQ-039 rst_n asserted mid-stream with m_valid=1, inj_pending=1, word_cnt=5 -> all outputs per REQ-029 without clock edge; back-to-back stream resumes one word per cycle.

Source files
------------

// File: rtl/hamming_stream_encoder.sv
// Streaming systematic Hamming encoder with a one-deep output register and single-bit fault injection.
// Define HAMMING_SECDED_EN to append an overall parity bit (extended SECDED code).
module hamming_stream_encoder #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1, for the legal range 1..57
    localparam int unsigned P = (DATA_W <= 1)  ? 2 :
                                (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 : 6,
`ifdef HAMMING_SECDED_EN
    localparam int unsigned CODE_W = DATA_W + P + 1,
`else
    localparam int unsigned CODE_W = DATA_W + P,
`endif
    localparam int unsigned INJ_W = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CODE_W-1:0] m_code,
    input  logic              inj_valid,
    input  logic [INJ_W-1:0]  inj_pos,
    output logic              inj_pending,
    output logic [CNT_W-1:0]  word_cnt
);

    logic              m_valid_q;
    logic [CODE_W-1:0] m_code_q;
    logic              inj_pending_q;
    logic [INJ_W-1:0]  inj_pos_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic              accept;
    logic              deliver;
    logic [P-1:0]      parity;
    logic [CODE_W-1:0] code_raw;
    logic [CODE_W-1:0] flip_mask;

    // Walks Hamming positions 3,5,6,7,9,... skipping powers of two; a data bit feeds
    // parity i when its position has bit i set.
    function automatic logic [P-1:0] calc_parity(input logic [DATA_W-1:0] d);
        logic [P-1:0] p;
        int unsigned  pos;
        p   = '0;
        pos = 2;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            for (int unsigned i = 0; i < P; i++) begin
                if (pos[i]) p[i] = p[i] ^ d[k];
            end
        end
        return p;
    endfunction

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;
    assign deliver = m_valid_q && m_ready;

    always_comb begin
        parity = calc_parity(s_data);
`ifdef HAMMING_SECDED_EN
        code_raw = {^{parity, s_data}, parity, s_data};
`else
        code_raw = {parity, s_data};
`endif
    end

    // Out-of-range positions match no bit, so the request is consumed without effect.
    always_comb begin
        flip_mask = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            flip_mask[i] = inj_pending_q && (inj_pos_q == INJ_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_code_q  <= '0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_code_q  <= code_raw ^ flip_mask;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // A request arriving with an accepted word arms for the next word, so it wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pending_q <= 1'b0;
            inj_pos_q     <= '0;
        end else if (inj_valid) begin
            inj_pending_q <= 1'b1;
            inj_pos_q     <= inj_pos;
        end else if (accept) begin
            inj_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (deliver) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign m_valid     = m_valid_q;
    assign m_code      = m_code_q;
    assign inj_pending = inj_pending_q;
    assign word_cnt    = word_cnt_q;

endmodule
